out_display_responder: RTL and testbench

- Responder end of the core's OUT handshake.
- The core raises `outctr` with the value to print, then stalls until `outend` rises.
- This block latches the signed 32-bit value and converts it to BCD sequentially (shift-add-3). It drives the eight seven-segment displays and returns `outend`, optionally gated by a user confirm button.
- Sits between the core's OUT path and the board displays, replacing a purely combinational display decoder.

---
 rtl/hc_io_pkg.sv | 30 +++
 rtl/bin2bcd_seq.sv | 74 +++++++
 rtl/out_display_responder.sv | 139 +++++++++++++
 tb/tb_out_display_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc_io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hc_io_pkg : shared types and seven-segment constants for the OUT responder
// Revision  : 1.0
// ---------------------------------------------------------------------------
package hc_io_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam int BCD_DIGITS = 10;

  // Active-low segments ordered {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    seg_of = SEG_BLANK;
    if (d <= 4'd9) seg_of = SEG_DIGIT[d];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin2bcd_seq : sequential shift-add-3 binary to BCD converter, one bit/cycle
// Revision    : 1.0
// ---------------------------------------------------------------------------
module bin2bcd_seq
  import hc_io_pkg::*;
#(
  parameter int CONV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] bin_i,
  output logic        done_o,
  output logic [39:0] bcd_o
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);

  logic [39:0]      bcd_q, bcd_d, bcd_adj;
  logic [31:0]      mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q, run_d;
  logic             last;

  assign last   = (cnt_q == CNT_W'(CONV_CYCLES));
  assign done_o = run_q & last;
  assign bcd_o  = bcd_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // done_o stays high for the single cycle after the final shift
  always_comb begin
    bcd_d = bcd_q;
    mag_d = mag_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      bcd_d = '0;
      mag_d = bin_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (last) begin
        run_d = 1'b0;
      end else begin
        {bcd_d, mag_d} = {bcd_adj[38:0], mag_q, 1'b0};
        cnt_d          = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bcd_q <= '0;
      mag_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      bcd_q <= bcd_d;
      mag_q <= mag_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/out_display_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// out_display_responder : OUT handshake responder driving eight 7-seg digits
// Revision              : 1.0
// ---------------------------------------------------------------------------
module out_display_responder
  import hc_io_pkg::*;
#(
  parameter int WAIT_ACK    = 0,
  parameter int CONV_CYCLES = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        outctr,
  input  logic [31:0] outdata,
  input  logic        confirm,
  output logic        busy,
  output logic        outend,
  output logic [6:0]  display0,
  output logic [6:0]  display1,
  output logic [6:0]  display2,
  output logic [6:0]  display3,
  output logic [6:0]  display4,
  output logic [6:0]  display5,
  output logic [6:0]  display6,
  output logic [6:0]  display7
);

  state_t      state_q, state_d;
  logic        outend_q, outend_d;
  logic        conf_prev_q, conf_prev_d;
  logic        sign_q, sign_d;
  logic [6:0]  disp_q [8];
  logic [6:0]  disp_d [8];
  logic [6:0]  seg_w  [8];

  logic        start_w;
  logic        done_w;
  logic [31:0] mag_w;
  logic [39:0] bcd_w;

  assign start_w = (state_q == IDLE) & outctr;
  // 0x80000000 negates to itself, which is the correct unsigned magnitude
  assign mag_w   = outdata[31] ? (~outdata + 32'd1) : outdata;

  bin2bcd_seq #(
    .CONV_CYCLES (CONV_CYCLES)
  ) u_bin2bcd (
    .clk     (clock),
    .rst     (reset),
    .start_i (start_w),
    .bin_i   (mag_w),
    .done_o  (done_w),
    .bcd_o   (bcd_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      outend_q    <= 1'b0;
      conf_prev_q <= 1'b0;
      sign_q      <= 1'b0;
      for (int i = 0; i < 8; i++) disp_q[i] <= SEG_BLANK;
    end else begin
      state_q     <= state_d;
      outend_q    <= outend_d;
      conf_prev_q <= conf_prev_d;
      sign_q      <= sign_d;
      for (int i = 0; i < 8; i++) disp_q[i] <= disp_d[i];
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (outctr)  state_d = CONVERT;
      CONVERT: if (done_w)  state_d = SHOW;
      SHOW:    if (!outctr) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // Leading zeros blank from the top; digit 0 is always lit
  always_comb begin
    logic       lead;
    logic [3:0] dig;
    lead = 1'b0;
    dig  = '0;
    for (int i = 6; i >= 0; i--) begin
      dig      = bcd_w[4*i +: 4];
      lead     = lead | (dig != 4'd0) | (i == 0);
      seg_w[i] = lead ? seg_of(dig) : SEG_BLANK;
    end
    seg_w[7] = sign_q ? SEG_MINUS : SEG_BLANK;
    if (|bcd_w[39:28]) begin
      for (int i = 0; i < 8; i++) seg_w[i] = SEG_MINUS;
    end
  end

  always_comb begin
    outend_d    = 1'b0;
    conf_prev_d = conf_prev_q;
    sign_d      = sign_q;
    for (int i = 0; i < 8; i++) disp_d[i] = disp_q[i];
    unique case (state_q)
      IDLE: begin
        if (outctr) sign_d = outdata[31];
      end
      CONVERT: begin
        if (done_w) begin
          outend_d    = (WAIT_ACK == 0);
          conf_prev_d = confirm;
          for (int i = 0; i < 8; i++) disp_d[i] = seg_w[i];
        end
      end
      SHOW: begin
        conf_prev_d = confirm;
        if (outctr) begin
          if (WAIT_ACK == 0) outend_d = 1'b1;
          else               outend_d = outend_q | (confirm & ~conf_prev_q);
        end
      end
      default: ;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign outend   = outend_q;
  assign display0 = disp_q[0];
  assign display1 = disp_q[1];
  assign display2 = disp_q[2];
  assign display3 = disp_q[3];
  assign display4 = disp_q[4];
  assign display5 = disp_q[5];
  assign display6 = disp_q[6];
  assign display7 = disp_q[7];

endmodule
`default_nettype wire

// File: tb/tb_out_display_responder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_out_display_responder : directed bench, WAIT_ACK=0 (dut0) and =1 (dut1)
// Revision                 : 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_out_display_responder;

  localparam logic [6:0] S_BL = 7'b1111111;
  localparam logic [6:0] S_MI = 7'b0111111;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010;
  localparam logic [6:0] S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000;

  logic        clk = 1'b0;
  logic        rst, outctr0, outctr1, confirm;
  logic [31:0] outdata;
  logic        busy0, busy1, outend0, outend1;
  logic [6:0]  a0, a1, a2, a3, a4, a5, a6, a7;
  logic [6:0]  b0, b1, b2, b3, b4, b5, b6, b7;
  wire  [6:0]  dA [8];
  wire  [6:0]  dB [8];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign dA[0] = a0; assign dA[1] = a1; assign dA[2] = a2; assign dA[3] = a3;
  assign dA[4] = a4; assign dA[5] = a5; assign dA[6] = a6; assign dA[7] = a7;
  assign dB[0] = b0; assign dB[1] = b1; assign dB[2] = b2; assign dB[3] = b3;
  assign dB[4] = b4; assign dB[5] = b5; assign dB[6] = b6; assign dB[7] = b7;

  out_display_responder #(.WAIT_ACK(0)) dut0 (
    .clock(clk), .reset(rst), .outctr(outctr0), .outdata(outdata), .confirm(confirm),
    .busy(busy0), .outend(outend0),
    .display0(a0), .display1(a1), .display2(a2), .display3(a3),
    .display4(a4), .display5(a5), .display6(a6), .display7(a7)
  );

  out_display_responder #(.WAIT_ACK(1)) dut1 (
    .clock(clk), .reset(rst), .outctr(outctr1), .outdata(outdata), .confirm(confirm),
    .busy(busy1), .outend(outend1),
    .display0(b0), .display1(b1), .display2(b2), .display3(b3),
    .display4(b4), .display5(b5), .display6(b6), .display7(b7)
  );

  // Request on dut0 accepted at the next edge (edge 0); returns #1 after edge 33
  task automatic request0(input logic [31:0] v);
    @(negedge clk);
    outdata = v;
    outctr0 = 1'b1;
    @(posedge clk);
    repeat (33) @(posedge clk);
    #1;
  endtask

  task automatic release0();
    @(negedge clk);
    outctr0 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    outdata = $urandom_range(1, 9999);
    outctr0 = 1'b1;
    outctr1 = 1'b1;
    confirm = 1'($urandom);
    repeat (33 + $urandom_range(0, 20)) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    outctr0 = 1'b0;
    outctr1 = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== S_BL) begin n_bad++; $display("FAIL reset_dut0_disp%0d: got %b want %b", i, dA[i], S_BL); end
      n_cmp++;
      if (dB[i] !== S_BL) begin n_bad++; $display("FAIL reset_dut1_disp%0d: got %b want %b", i, dB[i], S_BL); end
    end
    n_cmp++;
    if ({busy0, outend0, busy1, outend1} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 0000", {busy0, outend0, busy1, outend1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [6:0] exp [8];
    exp = '{S4, S3, S2, S1, S_BL, S_BL, S_BL, S_BL};
    @(negedge clk);
    outdata = 32'd1234;
    outctr0 = 1'b1;
    @(posedge clk);
    repeat (32) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, outend0} !== 2'b10) begin n_bad++; $display("FAIL basic_edge32: got busy/outend %b want 10", {busy0, outend0}); end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, outend0} !== 2'b11) begin n_bad++; $display("FAIL basic_edge33: got busy/outend %b want 11", {busy0, outend0}); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== exp[i]) begin n_bad++; $display("FAIL basic_disp%0d: got %b want %b", i, dA[i], exp[i]); end
    end
    release0();
    n_cmp++;
    if ({busy0, outend0} !== 2'b00) begin n_bad++; $display("FAIL basic_drop: got busy/outend %b want 00", {busy0, outend0}); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== exp[i]) begin n_bad++; $display("FAIL basic_hold%0d: got %b want %b", i, dA[i], exp[i]); end
    end
  endtask

  task automatic test_sign_zero();
    logic [6:0] exp [8];
    request0(32'hFFFF_FFFB);
    exp = '{S5, S_BL, S_BL, S_BL, S_BL, S_BL, S_BL, S_MI};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== exp[i]) begin n_bad++; $display("FAIL neg5_disp%0d: got %b want %b", i, dA[i], exp[i]); end
    end
    release0();
    request0(32'd0);
    exp = '{S0, S_BL, S_BL, S_BL, S_BL, S_BL, S_BL, S_BL};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== exp[i]) begin n_bad++; $display("FAIL zero_disp%0d: got %b want %b", i, dA[i], exp[i]); end
    end
    release0();
  endtask

  task automatic test_range();
    logic [31:0] vals [4];
    logic [6:0]  exp  [4][8];
    vals = '{32'd10000000, 32'h8000_0000, 32'd9999999, 32'd1000005};
    exp[0] = '{S_MI, S_MI, S_MI, S_MI, S_MI, S_MI, S_MI, S_MI};
    exp[1] = '{S_MI, S_MI, S_MI, S_MI, S_MI, S_MI, S_MI, S_MI};
    exp[2] = '{S9, S9, S9, S9, S9, S9, S9, S_BL};
    exp[3] = '{S5, S0, S0, S0, S0, S0, S1, S_BL};
    for (int v = 0; v < 4; v++) begin
      request0(vals[v]);
      n_cmp++;
      if (outend0 !== 1'b1) begin n_bad++; $display("FAIL range%0d_outend: got %b want 1", v, outend0); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (dA[i] !== exp[v][i]) begin n_bad++; $display("FAIL range%0d_disp%0d: got %b want %b", v, i, dA[i], exp[v][i]); end
      end
      release0();
    end
  endtask

  task automatic test_early_drop();
    @(negedge clk);
    outdata = 32'd42;
    outctr0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outctr0 = 1'b0;
    repeat (33) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, outend0} !== 2'b11) begin n_bad++; $display("FAIL early_show: got busy/outend %b want 11", {busy0, outend0}); end
    n_cmp++;
    if ({dA[1], dA[0]} !== {S4, S2}) begin n_bad++; $display("FAIL early_disp: got %b want %b", {dA[1], dA[0]}, {S4, S2}); end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, outend0} !== 2'b00) begin n_bad++; $display("FAIL early_pulse: got busy/outend %b want 00", {busy0, outend0}); end
  endtask

  task automatic test_wait_ack();
    @(negedge clk);
    confirm = 1'b1;
    outdata = 32'd77;
    outctr1 = 1'b1;
    @(posedge clk);
    repeat (33) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy1, outend1} !== 2'b10) begin n_bad++; $display("FAIL ack_entry: got busy/outend %b want 10", {busy1, outend1}); end
    n_cmp++;
    if ({dB[2], dB[1], dB[0]} !== {S_BL, S7, S7}) begin n_bad++; $display("FAIL ack_disp: got %b want %b", {dB[2], dB[1], dB[0]}, {S_BL, S7, S7}); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (outend1 !== 1'b0) begin n_bad++; $display("FAIL ack_held: got %b want 0", outend1); end
    @(negedge clk);
    confirm = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outend1 !== 1'b0) begin n_bad++; $display("FAIL ack_release: got %b want 0", outend1); end
    @(negedge clk);
    confirm = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outend1 !== 1'b1) begin n_bad++; $display("FAIL ack_press: got %b want 1", outend1); end
    @(negedge clk);
    outctr1 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy1, outend1} !== 2'b00) begin n_bad++; $display("FAIL ack_exit: got busy/outend %b want 00", {busy1, outend1}); end
    // Drop before any confirm: back to IDLE with outend never raised
    @(negedge clk);
    confirm = 1'b0;
    outdata = 32'd5;
    outctr1 = 1'b1;
    @(posedge clk);
    repeat (33) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy1, outend1, dB[0]} !== {2'b10, S5}) begin n_bad++; $display("FAIL noack_show: got %b want %b", {busy1, outend1, dB[0]}, {2'b10, S5}); end
    @(negedge clk);
    outctr1 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy1, outend1} !== 2'b00) begin n_bad++; $display("FAIL noack_exit: got busy/outend %b want 00", {busy1, outend1}); end
    @(negedge clk);
    confirm = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (outend1 !== 1'b0) begin n_bad++; $display("FAIL noack_idle_press: got %b want 0", outend1); end
    @(negedge clk);
    confirm = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [6:0] exp [8];
    @(negedge clk);
    outdata = 32'd123;
    outctr0 = 1'b1;
    @(posedge clk);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    outctr0 = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({busy0, outend0} !== 2'b00) begin n_bad++; $display("FAIL midrst_flags: got busy/outend %b want 00", {busy0, outend0}); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== S_BL) begin n_bad++; $display("FAIL midrst_disp%0d: got %b want %b", i, dA[i], S_BL); end
    end
    @(negedge clk);
    rst = 1'b0;
    request0(32'd7654321);
    exp = '{S1, S2, S3, S4, S5, S6, S7, S_BL};
    n_cmp++;
    if ({busy0, outend0} !== 2'b11) begin n_bad++; $display("FAIL after_rst_flags: got busy/outend %b want 11", {busy0, outend0}); end
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (dA[i] !== exp[i]) begin n_bad++; $display("FAIL after_rst_disp%0d: got %b want %b", i, dA[i], exp[i]); end
    end
    release0();
  endtask

  initial begin
    rst = 1'b1;
    outctr0 = 1'b0;
    outctr1 = 1'b0;
    confirm = 1'b0;
    outdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_basic();
    test_sign_zero();
    test_range();
    test_early_drop();
    test_wait_ack();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
